// File: rtl/md5_host_link.sv
// md5_host_link: host-side command initiator that serializes commands to cmd_parser and collects its replies.
module md5_host_link #(
    parameter int BYTE_GAP       = 0,
    parameter int BUSY_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_start,
    input  logic [7:0]  cmd_op,
    input  logic [15:0] cmd_len,
    input  logic [7:0]  resp_len,
    input  logic [7:0]  pl_data,
    input  logic        pl_valid,
    output logic        pl_ready,
    output logic [7:0]  rxd_data,
    output logic        rxd_data_ready,
    input  logic        txd_start,
    input  logic [7:0]  txd_data,
    output logic        txd_busy,
    output logic [7:0]  resp_data,
    output logic        resp_valid,
    output logic        resp_last,
    output logic        busy,
    output logic        done,
    output logic        err_timeout,
    output logic        err_unexpected
);
    localparam int GW = BYTE_GAP > 1 ? $clog2(BYTE_GAP) : 1;
    localparam int BW = BUSY_CYCLES > 0 ? $clog2(BUSY_CYCLES + 1) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    typedef enum logic [2:0] {IDLE, SEND_OP, SEND_PL, GAP, WAIT_RESP} state_t;
    state_t state, state_nx;
    logic [7:0] op_q, rcnt, last_byte;
    logic [15:0] pcnt;
    logic [GW-1:0] gcnt;
    logic [BW-1:0] bcnt;
    logic [TW-1:0] tcnt;
    logic take_pl, pl_final, capture, finish, timed_out;
    // a reply landing with the final payload byte is still counted
    always_comb begin
        take_pl = state == SEND_PL && pl_valid;
        pl_final = take_pl && pcnt == 16'd1;
        capture = txd_start && rcnt != 8'd0 && (state == WAIT_RESP || pl_final);
        finish = (capture && rcnt == 8'd1) || (state == WAIT_RESP && rcnt == 8'd0);
        timed_out = state == WAIT_RESP && !txd_start && rcnt != 8'd0 && tcnt == TW'(TIMEOUT_CYCLES - 1);
        state_nx = state;
        case (state)
            IDLE:      state_nx = cmd_start ? SEND_OP : IDLE;
            SEND_OP:   state_nx = BYTE_GAP > 0 ? GAP : pcnt != 16'd0 ? SEND_PL : WAIT_RESP;
            SEND_PL:   state_nx = !take_pl ? SEND_PL : pl_final ? (finish ? IDLE : WAIT_RESP) : BYTE_GAP > 0 ? GAP : SEND_PL;
            GAP:       state_nx = gcnt != GW'(0) ? GAP : pcnt != 16'd0 ? SEND_PL : WAIT_RESP;
            WAIT_RESP: state_nx = finish || timed_out ? IDLE : WAIT_RESP;
            default:   state_nx = IDLE;
        endcase
    end
    assign pl_ready = take_pl;
    assign rxd_data_ready = state == SEND_OP || take_pl;
    assign rxd_data = state == SEND_OP ? op_q : take_pl ? pl_data : last_byte;
    assign busy = state != IDLE;
    assign txd_busy = bcnt != BW'(0);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            op_q <= '0;
            rcnt <= '0;
            pcnt <= '0;
            gcnt <= '0;
            bcnt <= '0;
            tcnt <= '0;
            last_byte <= '0;
            resp_data <= '0;
            resp_valid <= 1'b0;
            resp_last <= 1'b0;
            done <= 1'b0;
            err_timeout <= 1'b0;
            err_unexpected <= 1'b0;
        end else begin
            state <= state_nx;
            resp_valid <= capture;
            resp_last <= capture && rcnt == 8'd1;
            done <= finish || timed_out;
            err_unexpected <= txd_start && state != WAIT_RESP && !capture;
            bcnt <= txd_start ? BW'(BUSY_CYCLES) : bcnt != BW'(0) ? bcnt - BW'(1) : bcnt;
            gcnt <= state == GAP ? gcnt - GW'(1) : GW'(BYTE_GAP - 1);
            tcnt <= state != WAIT_RESP || txd_start ? '0 : tcnt + TW'(1);
            if (capture) begin
                resp_data <= txd_data;
                rcnt <= rcnt - 8'd1;
            end
            if (take_pl) begin
                last_byte <= pl_data;
                pcnt <= pcnt - 16'd1;
            end
            if (state == SEND_OP) last_byte <= op_q;
            if (state == IDLE && cmd_start) begin
                op_q <= cmd_op;
                pcnt <= cmd_len;
                rcnt <= resp_len;
                err_timeout <= 1'b0;
            end
            if (timed_out) err_timeout <= 1'b1;
        end
    end
endmodule

// File: tb/tb_md5_host_link.sv
// tb_md5_host_link: directed scenarios for md5_host_link (gapless instance plus a BYTE_GAP=2 instance).
module tb_md5_host_link;
    logic clk = 0, reset = 0;
    logic cmd_start = 0, pl_valid = 0, txd_start = 0;
    logic [7:0] cmd_op = 0, resp_len = 0, pl_data = 0, txd_data = 0;
    logic [15:0] cmd_len = 0;
    logic pl_ready, rxd_data_ready, txd_busy, resp_valid, resp_last, busy, done, err_timeout, err_unexpected;
    logic [7:0] rxd_data, resp_data;
    logic g_cmd_start = 0, g_pl_valid = 0, g_txd_start = 0;
    logic [7:0] g_cmd_op = 0, g_resp_len = 0, g_pl_data = 0, g_txd_data = 0;
    logic [15:0] g_cmd_len = 0;
    logic g_pl_ready, g_rxd_data_ready, g_txd_busy, g_resp_valid, g_resp_last, g_busy, g_done, g_err_timeout, g_err_unexpected;
    logic [7:0] g_rxd_data, g_resp_data;
    int checks = 0, errors = 0;
    int cyc = 0, done_n = 0, done_t = 0, unexp_n = 0, g_done_n = 0;
    logic [7:0] rx_q[$], g_rx_q[$];
    int rx_t[$], g_rx_t[$], rs_t[$];
    logic [8:0] rs_q[$];
    logic [7:0] pl_buf[64];
    logic [7:0] rp_buf[32];

    always #5 clk = ~clk;

    md5_host_link #(.BYTE_GAP(0), .BUSY_CYCLES(4), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_op(cmd_op), .cmd_len(cmd_len),
        .resp_len(resp_len), .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
        .rxd_data(rxd_data), .rxd_data_ready(rxd_data_ready), .txd_start(txd_start),
        .txd_data(txd_data), .txd_busy(txd_busy), .resp_data(resp_data), .resp_valid(resp_valid),
        .resp_last(resp_last), .busy(busy), .done(done), .err_timeout(err_timeout),
        .err_unexpected(err_unexpected));

    md5_host_link #(.BYTE_GAP(2), .BUSY_CYCLES(4), .TIMEOUT_CYCLES(64)) dut_g (
        .clk(clk), .reset(reset), .cmd_start(g_cmd_start), .cmd_op(g_cmd_op), .cmd_len(g_cmd_len),
        .resp_len(g_resp_len), .pl_data(g_pl_data), .pl_valid(g_pl_valid), .pl_ready(g_pl_ready),
        .rxd_data(g_rxd_data), .rxd_data_ready(g_rxd_data_ready), .txd_start(g_txd_start),
        .txd_data(g_txd_data), .txd_busy(g_txd_busy), .resp_data(g_resp_data), .resp_valid(g_resp_valid),
        .resp_last(g_resp_last), .busy(g_busy), .done(g_done), .err_timeout(g_err_timeout),
        .err_unexpected(g_err_unexpected));

    always @(negedge clk) begin
        cyc++;
        if (rxd_data_ready) begin rx_q.push_back(rxd_data); rx_t.push_back(cyc); end
        if (resp_valid) begin rs_q.push_back({resp_last, resp_data}); rs_t.push_back(cyc); end
        if (done) begin done_n++; done_t = cyc; end
        if (err_unexpected) unexp_n++;
        if (g_rxd_data_ready) begin g_rx_q.push_back(g_rxd_data); g_rx_t.push_back(cyc); end
        if (g_done) g_done_n++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rx_q.delete(); rx_t.delete(); rs_q.delete(); rs_t.delete();
    endtask

    task automatic issue_cmd(input logic [7:0] op, input logic [15:0] len, input logic [7:0] rl);
        step();
        cmd_op = op; cmd_len = len; resp_len = rl; cmd_start = 1;
        step();
        cmd_start = 0;
    endtask

    task automatic feed(input int n, input int stall_at, input int stall_len);
        int i = 0, st = 0, guard = 0;
        while (i < n && guard < 400) begin
            pl_valid = !(i == stall_at && st < stall_len);
            pl_data = pl_buf[i];
            @(negedge clk);
            if (!pl_valid) st++;
            else if (pl_ready) i++;
            step();
            guard++;
        end
        pl_valid = 0;
    endtask

    task automatic reply(input int first, input int n);
        for (int k = first; k < first + n; k++) begin
            txd_data = rp_buf[k];
            txd_start = 1;
            step();
            txd_start = 0;
            for (int w = 0; w < 20 && txd_busy; w++) step();
            step();
        end
    endtask

    task automatic wait_done(input int n0, input int limit, output bit ok);
        int w = 0;
        while (done_n == n0 && w < limit) begin
            @(posedge clk);
            w++;
        end
        ok = done_n != n0;
        #1;
    endtask

    task automatic test_reset();
        reset = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1;
        @(negedge clk);
        checks++;
        if ({pl_ready, rxd_data_ready, txd_busy, resp_valid, resp_last, busy, done, err_timeout, err_unexpected} !== 9'h0) begin
            errors++; $display("FAIL reset_flags got=%b want=000000000",
                {pl_ready, rxd_data_ready, txd_busy, resp_valid, resp_last, busy, done, err_timeout, err_unexpected});
        end
        checks++;
        if (rxd_data !== 8'h00 || resp_data !== 8'h00) begin
            errors++; $display("FAIL reset_data rxd=%h resp=%h want 00 00", rxd_data, resp_data);
        end
    endtask

    task automatic test_command();
        int n0 = done_n;
        bit ok;
        clear_logs();
        for (int k = 0; k < 10; k++) rp_buf[k] = 8'(10 - k);
        issue_cmd(8'h04, 16'd0, 8'd10);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || rxd_data_ready !== 1'b1 || rxd_data !== 8'h04) begin
            errors++; $display("FAIL test_op_strobe busy=%b rdy=%b data=%h want 1 1 04", busy, rxd_data_ready, rxd_data);
        end
        step();
        reply(0, 10);
        wait_done(n0, 100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL test_done got=0 want=1"); end
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h04) begin
            errors++; $display("FAIL test_rx_count got=%0d want=1", rx_q.size());
        end
        checks++;
        if (rs_q.size() != 10) begin
            errors++; $display("FAIL test_resp_count got=%0d want=10", rs_q.size());
        end else begin
            for (int k = 0; k < 10; k++) begin
                checks++;
                if (rs_q[k] !== {k == 9, 8'(10 - k)}) begin
                    errors++; $display("FAIL test_resp[%0d] got=%h want=%h", k, rs_q[k], {k == 9, 8'(10 - k)});
                end
            end
        end
        checks++;
        if (err_timeout !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL test_final err_timeout=%b busy=%b want 0 0", err_timeout, busy);
        end
    endtask

    task automatic test_set_hash();
        logic [127:0] hv = 128'ha2004f37730b9445670a738fa0fc9ee5;
        int n0 = done_n;
        bit ok, bad_d = 0, bad_t = 0;
        clear_logs();
        for (int i = 0; i < 16; i++) pl_buf[i] = hv[127 - 8 * i -: 8];
        rp_buf[0] = 8'hAA;
        issue_cmd(8'h01, 16'd16, 8'd1);
        feed(16, -1, 0);
        reply(0, 1);
        wait_done(n0, 100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL hash_done got=0 want=1"); end
        checks++;
        if (rx_q.size() != 17) begin
            errors++; $display("FAIL hash_rx_count got=%0d want=17", rx_q.size());
        end else begin
            if (rx_q[0] !== 8'h01) bad_d = 1;
            for (int i = 0; i < 16; i++) begin
                if (rx_q[i + 1] !== pl_buf[i]) bad_d = 1;
                if (rx_t[i + 1] - rx_t[i] != 1) bad_t = 1;
            end
            checks++;
            if (bad_d) begin errors++; $display("FAIL hash_rx_data got first=%h,%h want 01,a2", rx_q[0], rx_q[1]); end
            checks++;
            if (bad_t) begin errors++; $display("FAIL hash_rx_spacing got=non-consecutive want=consecutive"); end
        end
        checks++;
        if (rs_q.size() != 1 || rs_q[0] !== 9'h1AA) begin
            errors++; $display("FAIL hash_ack count=%0d want 1 byte 1aa", rs_q.size());
        end
    endtask

    task automatic test_string();
        string s = "Hello. The quick brown fox jumps over the lazy dog.";
        int n0 = done_n;
        bit ok, bad_d = 0, bad_t = 0;
        clear_logs();
        pl_buf[0] = 8'h00;
        pl_buf[1] = 8'h33;
        for (int i = 0; i < 51; i++) pl_buf[i + 2] = s[i];
        rp_buf[0] = 8'h55;
        issue_cmd(8'h02, 16'd53, 8'd1);
        feed(53, 20, 3);
        reply(0, 1);
        wait_done(n0, 100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL str_done got=0 want=1"); end
        checks++;
        if (rx_q.size() != 54) begin
            errors++; $display("FAIL str_rx_count got=%0d want=54", rx_q.size());
        end else begin
            if (rx_q[0] !== 8'h02) bad_d = 1;
            for (int i = 0; i < 53; i++) begin
                if (rx_q[i + 1] !== pl_buf[i]) bad_d = 1;
                if (i != 20 && rx_t[i + 1] - rx_t[i] != 1) bad_t = 1;
            end
            checks++;
            if (bad_d) begin errors++; $display("FAIL str_rx_order got=out-of-order want=in-order"); end
            checks++;
            if (bad_t) begin errors++; $display("FAIL str_rx_spacing got=gap want=back-to-back"); end
            checks++;
            if (rx_t[21] - rx_t[20] != 4) begin
                errors++; $display("FAIL str_stall_gap got=%0d want=4", rx_t[21] - rx_t[20]);
            end
        end
        checks++;
        if (rs_q.size() != 1 || rs_q[0] !== 9'h155) begin
            errors++; $display("FAIL str_resp count=%0d want 1 byte 155", rs_q.size());
        end
    endtask

    task automatic test_read_match();
        int n0 = done_n;
        bit ok, pre;
        logic [4:0] pat;
        clear_logs();
        rp_buf[0] = 8'h00;
        rp_buf[1] = 8'h05;
        for (int k = 2; k < 21; k++) rp_buf[k] = 8'h30 + 8'(k);
        issue_cmd(8'h03, 16'd0, 8'd21);
        step();
        txd_data = rp_buf[0];
        txd_start = 1;
        @(negedge clk);
        pre = txd_busy;
        step();
        txd_start = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            pat[4 - k] = txd_busy;
            step();
        end
        checks++;
        if (pre !== 1'b0 || pat !== 5'b11110) begin
            errors++; $display("FAIL rm_txd_busy got=%b%b want=011110", pre, pat);
        end
        reply(1, 20);
        wait_done(n0, 100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rm_done got=0 want=1"); end
        checks++;
        if (rs_q.size() != 21) begin
            errors++; $display("FAIL rm_count got=%0d want=21", rs_q.size());
        end else begin
            for (int k = 0; k < 21; k++) begin
                checks++;
                if (rs_q[k] !== {k == 20, rp_buf[k]}) begin
                    errors++; $display("FAIL rm_byte[%0d] got=%h want=%h", k, rs_q[k], {k == 20, rp_buf[k]});
                end
            end
        end
    endtask

    task automatic test_timeout();
        int n0 = done_n;
        bit ok;
        clear_logs();
        rp_buf[0] = 8'h5A;
        issue_cmd(8'h03, 16'd0, 8'd2);
        step();
        reply(0, 1);
        wait_done(n0, 200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL to_done got=0 want=1"); end
        checks++;
        if (err_timeout !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL to_flags err_timeout=%b busy=%b want 1 0", err_timeout, busy);
        end
        checks++;
        if (rs_q.size() != 1 || rs_q[0] !== 9'h05A) begin
            errors++; $display("FAIL to_resp count=%0d want 1 byte 05a", rs_q.size());
        end else begin
            checks++;
            if (done_t - rs_t[0] != 64) begin
                errors++; $display("FAIL to_latency got=%0d want=64", done_t - rs_t[0]);
            end
        end
    endtask

    task automatic test_unexpected();
        int u0 = unexp_n, ns = rs_q.size();
        logic [4:0] pat;
        txd_data = 8'h77;
        txd_start = 1;
        step();
        txd_start = 0;
        step();
        txd_start = 1;
        step();
        txd_start = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            pat[4 - k] = txd_busy;
            step();
        end
        checks++;
        if (pat !== 5'b11110) begin errors++; $display("FAIL ux_busy_restart got=%b want=11110", pat); end
        checks++;
        if (unexp_n - u0 != 2) begin errors++; $display("FAIL ux_pulses got=%0d want=2", unexp_n - u0); end
        checks++;
        if (rs_q.size() != ns) begin errors++; $display("FAIL ux_no_resp got=%0d want=%0d", rs_q.size(), ns); end
        checks++;
        if (err_timeout !== 1'b1) begin errors++; $display("FAIL ux_sticky got=%b want=1", err_timeout); end
    endtask

    task automatic test_overlap();
        int n0 = done_n, u0 = unexp_n;
        bit ok;
        clear_logs();
        pl_valid = 1;
        pl_data = 8'h10;
        issue_cmd(8'h02, 16'd2, 8'd1);
        checks++;
        if (err_timeout !== 1'b0) begin errors++; $display("FAIL ov_clear_timeout got=%b want=0", err_timeout); end
        step();
        step();
        pl_data = 8'h20;
        txd_data = 8'h99;
        txd_start = 1;
        @(negedge clk);
        checks++;
        if (pl_ready !== 1'b1 || rxd_data !== 8'h20) begin
            errors++; $display("FAIL ov_align pl_ready=%b rxd=%h want 1 20", pl_ready, rxd_data);
        end
        step();
        txd_start = 0;
        pl_valid = 0;
        wait_done(n0, 20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL ov_done got=0 want=1"); end
        checks++;
        if (rs_q.size() != 1 || rs_q[0] !== 9'h199) begin
            errors++; $display("FAIL ov_resp count=%0d want 1 byte 199", rs_q.size());
        end
        checks++;
        if (unexp_n != u0 || rx_q.size() != 3) begin
            errors++; $display("FAIL ov_side unexp=%0d rx=%0d want 0 3", unexp_n - u0, rx_q.size());
        end
        repeat (6) step();
    endtask

    task automatic test_reset_abort();
        int n0 = done_n;
        for (int i = 0; i < 8; i++) pl_buf[i] = 8'hE0 + 8'(i);
        pl_valid = 1;
        pl_data = pl_buf[0];
        issue_cmd(8'h02, 16'd8, 8'd1);
        step();
        step();
        step();
        checks++;
        if (busy !== 1'b1 || pl_ready !== 1'b1) begin
            errors++; $display("FAIL abort_pre busy=%b pl_ready=%b want 1 1", busy, pl_ready);
        end
        reset = 0;
        #1;
        checks++;
        if ({pl_ready, rxd_data_ready, txd_busy, resp_valid, resp_last, busy, done, err_timeout, err_unexpected} !== 9'h0
            || rxd_data !== 8'h00 || resp_data !== 8'h00) begin
            errors++; $display("FAIL abort_outputs busy=%b pl_ready=%b rdy=%b rxd=%h want all 0", busy, pl_ready, rxd_data_ready, rxd_data);
        end
        repeat (3) @(posedge clk);
        #1 reset = 1;
        pl_valid = 0;
        repeat (3) step();
        checks++;
        if (done_n != n0 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_no_done done_pulses=%0d busy=%b want 0 0", done_n - n0, busy);
        end
    endtask

    task automatic test_gap();
        logic [7:0] gv[4] = '{8'h11, 8'h22, 8'h33, 8'h00};
        int n0 = g_done_n, got = 0, guard = 0;
        bit bad_d = 0, bad_t = 0;
        g_rx_q.delete();
        g_rx_t.delete();
        g_pl_valid = 1;
        g_pl_data = gv[0];
        step();
        g_cmd_op = 8'h02; g_cmd_len = 16'd3; g_resp_len = 8'd1; g_cmd_start = 1;
        step();
        g_cmd_start = 0;
        while (got < 3 && guard < 40) begin
            @(negedge clk);
            if (g_pl_ready) got++;
            step();
            g_pl_data = gv[got];
            guard++;
        end
        g_pl_valid = 0;
        g_txd_data = 8'hC3;
        g_txd_start = 1;
        step();
        g_txd_start = 0;
        for (int w = 0; w < 20 && g_done_n == n0; w++) step();
        checks++;
        if (g_done_n == n0 || g_resp_data !== 8'hC3) begin
            errors++; $display("FAIL gap_done done=%0d resp=%h want 1 c3", g_done_n - n0, g_resp_data);
        end
        checks++;
        if (g_rx_q.size() != 4) begin
            errors++; $display("FAIL gap_rx_count got=%0d want=4", g_rx_q.size());
        end else begin
            if (g_rx_q[0] !== 8'h02) bad_d = 1;
            for (int i = 0; i < 3; i++) begin
                if (g_rx_q[i + 1] !== gv[i]) bad_d = 1;
                if (g_rx_t[i + 1] - g_rx_t[i] != 3) bad_t = 1;
            end
            checks++;
            if (bad_d) begin errors++; $display("FAIL gap_rx_data got=%h,%h want 02,11", g_rx_q[0], g_rx_q[1]); end
            checks++;
            if (bad_t) begin errors++; $display("FAIL gap_spacing got=%0d want=3", g_rx_t[1] - g_rx_t[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_command();
        test_set_hash();
        test_string();
        test_read_match();
        test_timeout();
        test_unexpected();
        test_overlap();
        test_reset_abort();
        test_gap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
